// File: rtl/dma_csr_pkg.sv
// Shared definitions for the DMA control/status register block.
// Covers the register map, the CTRL/STATUS bit positions and the launch FSM states.
package dma_csr_pkg;

    localparam logic [7:0] ADDR_LAYER  = 8'h50;
    localparam logic [7:0] ADDR_CTRL   = 8'h51;
    localparam logic [7:0] ADDR_COUNT  = 8'h52;
    localparam logic [7:0] ADDR_STATUS = 8'h53;
    localparam logic [7:0] ADDR_BURST  = 8'h54;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_ERR       = 2;
    localparam int STAT_START_REJ = 3;
    localparam int STAT_BEAT_LSB  = 16;

    localparam int BURST_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } dma_state_t;

    // The engine cannot handle a zero-length burst, so 0 becomes 1 and
    // anything above BURST_MAX is pinned to BURST_MAX.
    function automatic logic [4:0] clamp_burst(input logic [31:0] value);
        if (value == 32'd0)
            return 5'd1;
        else if (value > 32'(BURST_MAX))
            return 5'(BURST_MAX);
        else
            return value[4:0];
    endfunction

endpackage

// File: rtl/dma_csr_regfile.sv
// CSR block that configures the DMA engine and launches it.
// It also tracks progress, with sticky status flags and a level interrupt.
module dma_csr_regfile
    import dma_csr_pkg::*;
#(
    parameter int CSR_ADDR_WIDTH = 8,
    parameter int CSR_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_addr,
    input  logic                      csr_wen,
    input  logic                      csr_ren,
    input  logic [CSR_DATA_WIDTH-1:0] csr_wdata,
    output logic [CSR_DATA_WIDTH-1:0] csr_rdata,
    output logic                      dma_start_valid,
    input  logic                      dma_start_ready,
    output logic [7:0]                dma_layer,
    output logic [15:0]               dma_count,
    output logic [4:0]                dma_burst,
    input  logic                      dma_beat,
    input  logic                      dma_done,
    input  logic                      dma_err,
    output logic                      dma_abort,
    output logic                      busy,
    output logic                      irq
);

    dma_state_t  state_reg, state_next;
    logic [7:0]  layer_reg, layer_next;
    logic [15:0] count_reg, count_next;
    logic [4:0]  burst_reg, burst_next;
    logic [15:0] beat_reg, beat_next;
    logic        irq_en_reg, irq_en_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    logic        rej_reg, rej_next;
    logic        abort_reg, abort_next;
    logic        irq_reg, irq_next;

    logic hit_layer, hit_ctrl, hit_count, hit_status, hit_burst;
    logic start_wr, abort_wr, is_idle;
    logic done_set, err_set, rej_set;

    // csr_ren is informational only; reads have no side effects.
    logic unused_bits;
    assign unused_bits = ^{csr_ren, csr_wdata};

    assign hit_layer  = (csr_addr == CSR_ADDR_WIDTH'(ADDR_LAYER));
    assign hit_ctrl   = (csr_addr == CSR_ADDR_WIDTH'(ADDR_CTRL));
    assign hit_count  = (csr_addr == CSR_ADDR_WIDTH'(ADDR_COUNT));
    assign hit_status = (csr_addr == CSR_ADDR_WIDTH'(ADDR_STATUS));
    assign hit_burst  = (csr_addr == CSR_ADDR_WIDTH'(ADDR_BURST));

    assign is_idle  = (state_reg == ST_IDLE);
    assign start_wr = csr_wen && hit_ctrl && csr_wdata[CTRL_START];
    assign abort_wr = csr_wen && hit_ctrl && csr_wdata[CTRL_ABORT];

    always_comb begin
        state_next  = state_reg;
        layer_next  = layer_reg;
        count_next  = count_reg;
        burst_next  = burst_reg;
        beat_next   = beat_reg;
        irq_en_next = irq_en_reg;
        done_next   = done_reg;
        err_next    = err_reg;
        rej_next    = rej_reg;
        abort_next  = 1'b0;
        done_set    = 1'b0;
        err_set     = 1'b0;
        rej_set     = 1'b0;

        // Transfer parameters are frozen while busy; a write attempt is flagged instead.
        if (csr_wen && hit_layer) begin
            if (is_idle) layer_next = csr_wdata[7:0];
            else         rej_set = 1'b1;
        end
        if (csr_wen && hit_count) begin
            if (is_idle) count_next = csr_wdata[15:0];
            else         rej_set = 1'b1;
        end
        if (csr_wen && hit_burst) begin
            if (is_idle) burst_next = clamp_burst(32'(csr_wdata));
            else         rej_set = 1'b1;
        end
        if (csr_wen && hit_ctrl)
            irq_en_next = csr_wdata[CTRL_IRQ_EN];
        if (csr_wen && hit_status) begin
            if (csr_wdata[STAT_DONE])      done_next = 1'b0;
            if (csr_wdata[STAT_ERR])       err_next  = 1'b0;
            if (csr_wdata[STAT_START_REJ]) rej_next  = 1'b0;
        end
        if (start_wr && !is_idle)
            rej_set = 1'b1;

        case (state_reg)
            ST_IDLE: begin
                if (start_wr) begin
                    if (count_reg != 16'd0) begin
                        state_next = ST_REQ;
                        beat_next  = 16'd0;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                if (abort_wr || dma_err) begin
                    err_set    = 1'b1;
                    abort_next = abort_wr;
                    state_next = ST_IDLE;
                end else if (dma_start_ready) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_wr || dma_err) begin
                    err_set    = 1'b1;
                    abort_next = abort_wr;
                    state_next = ST_IDLE;
                end else begin
                    if (dma_beat && beat_reg != 16'hFFFF)
                        beat_next = beat_reg + 16'd1;
                    if (dma_done || beat_next == count_reg)
                        state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done_set   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Hardware events override a W1C clear landing in the same cycle.
        if (done_set) done_next = 1'b1;
        if (err_set)  err_next  = 1'b1;
        if (rej_set)  rej_next  = 1'b1;

        irq_next = irq_en_next & (done_next | err_next);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            layer_reg  <= 8'd0;
            count_reg  <= 16'd0;
            burst_reg  <= 5'd1;
            beat_reg   <= 16'd0;
            irq_en_reg <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            rej_reg    <= 1'b0;
            abort_reg  <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            layer_reg  <= layer_next;
            count_reg  <= count_next;
            burst_reg  <= burst_next;
            beat_reg   <= beat_next;
            irq_en_reg <= irq_en_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            rej_reg    <= rej_next;
            abort_reg  <= abort_next;
            irq_reg    <= irq_next;
        end
    end

    always_comb begin
        csr_rdata = '0;
        if (hit_layer) begin
            csr_rdata[7:0] = layer_reg;
        end else if (hit_ctrl) begin
            csr_rdata[CTRL_IRQ_EN] = irq_en_reg;
        end else if (hit_count) begin
            csr_rdata[15:0] = count_reg;
        end else if (hit_status) begin
            csr_rdata[STAT_BUSY]      = !is_idle;
            csr_rdata[STAT_DONE]      = done_reg;
            csr_rdata[STAT_ERR]       = err_reg;
            csr_rdata[STAT_START_REJ] = rej_reg;
            csr_rdata[STAT_BEAT_LSB +: 16] = beat_reg;
        end else if (hit_burst) begin
            csr_rdata[4:0] = burst_reg;
        end
    end

    assign dma_start_valid = (state_reg == ST_REQ);
    assign dma_layer       = layer_reg;
    assign dma_count       = count_reg;
    assign dma_burst       = burst_reg;
    assign dma_abort       = abort_reg;
    assign busy            = !is_idle;
    assign irq             = irq_reg;

endmodule

// File: tb/tb_dma_csr_regfile.sv
// Directed bench for dma_csr_regfile.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dma_csr_regfile;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  csr_addr = 8'h00;
    logic        csr_wen = 1'b0;
    logic        csr_ren = 1'b0;
    logic [31:0] csr_wdata = 32'h0;
    logic [31:0] csr_rdata;
    logic        dma_start_valid;
    logic        dma_start_ready = 1'b0;
    logic [7:0]  dma_layer;
    logic [15:0] dma_count;
    logic [4:0]  dma_burst;
    logic        dma_beat = 1'b0;
    logic        dma_done = 1'b0;
    logic        dma_err = 1'b0;
    logic        dma_abort;
    logic        busy;
    logic        irq;

    int checks = 0;
    int errors = 0;
    int vcnt;
    int pcnt;
    logic seen;

    dma_csr_regfile #(.CSR_ADDR_WIDTH(8), .CSR_DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_addr(csr_addr), .csr_wen(csr_wen), .csr_ren(csr_ren),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .dma_start_valid(dma_start_valid), .dma_start_ready(dma_start_ready),
        .dma_layer(dma_layer), .dma_count(dma_count), .dma_burst(dma_burst),
        .dma_beat(dma_beat), .dma_done(dma_done), .dma_err(dma_err),
        .dma_abort(dma_abort), .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // All tasks are entered and left on a falling edge.
    task automatic csr_write(input logic [7:0] addr, input logic [31:0] data);
        csr_addr  = addr;
        csr_wdata = data;
        csr_wen   = 1'b1;
        @(negedge clk);
        csr_wen   = 1'b0;
    endtask

    task automatic csr_read_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        csr_addr = addr;
        csr_ren  = 1'b1;
        #1;
        check(tag, csr_rdata, exp);
        csr_ren  = 1'b0;
    endtask

    task automatic start_and_accept();
        csr_write(8'h51, 32'h5);
        dma_start_ready = 1'b1;
        @(negedge clk);
        dma_start_ready = 1'b0;
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) begin
            dma_beat = 1'b1;
            @(negedge clk);
        end
        dma_beat = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset values
        csr_read_check("rst_layer", 8'h50, 32'h0);
        csr_read_check("rst_count", 8'h52, 32'h0);
        csr_read_check("rst_burst", 8'h54, 32'h1);
        csr_read_check("rst_status", 8'h53, 32'h0);
        check("rst_outs", {27'd0, dma_start_valid, dma_abort, irq, busy, 1'b0}, 32'h0);

        // Basic transfer: COUNT=4, BURST=8, ready on third REQ cycle, 4 beats
        csr_write(8'h52, 32'd4);
        csr_write(8'h54, 32'd8);
        csr_write(8'h50, 32'h3A);
        check("cfg_outs", {3'd0, dma_burst, dma_layer, dma_count}, {3'd0, 5'd8, 8'h3A, 16'd4});
        csr_write(8'h51, 32'h1);
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (dma_start_valid) vcnt++;
            dma_start_ready = (i == 2);
            @(negedge clk);
        end
        dma_start_ready = 1'b0;
        check("valid_cycles", 32'(vcnt), 32'd3);
        beats(4);
        @(negedge clk);
        csr_read_check("xfer_status", 8'h53, 32'h0004_0002);
        check("xfer_busy", {31'd0, busy}, 32'd0);
        csr_write(8'h53, 32'h2);
        csr_read_check("w1c_done", 8'h53, 32'h0004_0000);

        // BURST clamping and unmapped address
        csr_write(8'h54, 32'd0);
        csr_read_check("burst_0", 8'h54, 32'd1);
        csr_write(8'h54, 32'd20);
        csr_read_check("burst_20", 8'h54, 32'd16);
        csr_write(8'h60, 32'hFFFF_FFFF);
        csr_read_check("unmapped", 8'h60, 32'h0);
        csr_read_check("ctrl_rd", 8'h51, 32'h0);

        // Zero-length START
        csr_write(8'h52, 32'd0);
        csr_write(8'h51, 32'h1);
        seen = dma_start_valid;
        @(negedge clk);
        seen = seen | dma_start_valid;
        check("zero_no_valid", {31'd0, seen}, 32'd0);
        csr_read_check("zero_done", 8'h53, 32'h0004_0002);
        csr_write(8'h53, 32'h2);

        // ABORT during RUN with interrupt enabled
        csr_write(8'h51, 32'h4);
        csr_write(8'h52, 32'd10);
        start_and_accept();
        beats(2);
        csr_read_check("run_status", 8'h53, 32'h0002_0001);
        csr_write(8'h51, 32'h6);
        pcnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (dma_abort) pcnt++;
            @(negedge clk);
        end
        check("abort_pulses", 32'(pcnt), 32'd1);
        csr_read_check("abort_status", 8'h53, 32'h0002_0004);
        check("abort_irq", {31'd0, irq}, 32'd1);
        csr_write(8'h53, 32'h4);
        csr_read_check("err_clr", 8'h53, 32'h0002_0000);
        check("irq_clr", {31'd0, irq}, 32'd0);

        // Rejected START/COUNT during RUN, W1C DONE coincident with completion
        csr_write(8'h52, 32'd3);
        start_and_accept();
        csr_write(8'h51, 32'h5);
        csr_write(8'h52, 32'd7);
        check("count_frozen", {16'd0, dma_count}, 32'd3);
        csr_read_check("rej_status", 8'h53, 32'h0000_0009);
        beats(3);
        check("in_done_busy", {31'd0, busy}, 32'd1);
        csr_write(8'h53, 32'hA);
        csr_read_check("done_wins", 8'h53, 32'h0003_0002);
        check("done_irq", {31'd0, irq}, 32'd1);
        csr_write(8'h53, 32'h2);

        // Engine error during RUN
        csr_write(8'h51, 32'h0);
        csr_write(8'h52, 32'd5);
        csr_write(8'h51, 32'h1);
        dma_start_ready = 1'b1;
        @(negedge clk);
        dma_start_ready = 1'b0;
        beats(1);
        dma_err = 1'b1;
        @(negedge clk);
        dma_err = 1'b0;
        csr_read_check("err_status", 8'h53, 32'h0001_0004);
        csr_write(8'h53, 32'h4);

        // Reset in the middle of a transfer
        csr_write(8'h50, 32'h11);
        csr_write(8'h54, 32'd4);
        csr_write(8'h51, 32'h4);
        csr_write(8'h52, 32'd10);
        start_and_accept();
        beats(2);
        csr_write(8'h51, 32'h5);
        rst_n = 1'b0;
        seen = dma_abort;
        @(negedge clk);
        seen = seen | dma_abort;
        rst_n = 1'b1;
        @(negedge clk);
        seen = seen | dma_abort;
        check("rst_no_abort", {31'd0, seen}, 32'd0);
        csr_read_check("rst2_layer", 8'h50, 32'h0);
        csr_read_check("rst2_count", 8'h52, 32'h0);
        csr_read_check("rst2_burst", 8'h54, 32'h1);
        csr_read_check("rst2_status", 8'h53, 32'h0);
        csr_read_check("rst2_ctrl", 8'h51, 32'h0);
        check("rst2_outs", {27'd0, dma_start_valid, dma_abort, irq, busy, 1'b0}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
